booth_pp_seq_enc: RTL and testbench



---
 rtl/booth_pp_seq_enc.sv | 142 ++++++++++++++
 tb/tb_booth_pp_seq_enc.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_pp_seq_enc.sv
// booth_pp_seq_enc
// Sequential radix-4 Booth partial-product generator for an unsigned
// 11x11 multiply. One operand pair is taken through a valid/ready
// handshake, and one multiplier triplet is encoded per clock into a
// six-entry bank. The whole bank is then presented in parallel and held
// until the downstream reduction stage accepts it.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// ENC   | encoding triplet cnt into bank[cnt], busy=1
// HOLD  | bank complete, out_valid=1 until out_ready
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_valid/ready   operand handshake (a multiplicand, b multiplier)
//   out_valid/ready  bank handshake
//   pp1..pp6         partial products, pp1 has weight 4^0
//   signs            negate flag per partial product (bit k -> pp(k+1))
//   busy             high while encoding
module booth_pp_seq_enc (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] a,
  input  logic [10:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] pp1,
  output logic [11:0] pp2,
  output logic [11:0] pp3,
  output logic [11:0] pp4,
  output logic [11:0] pp5,
  output logic [11:0] pp6,
  output logic [5:0]  signs,
  output logic        busy
);

  localparam int numbit  = 11;
  localparam int pp_deep = 6;
  localparam logic [2:0] cnt_last = 3'(pp_deep - 1);

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_enc  = 2'd1,
    st_hold = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [numbit:0]   m_q;
  logic [numbit:0]   b_q;
  logic [2:0]        cnt;
  logic [numbit:0]   bank [pp_deep];
  logic [pp_deep-1:0] sign_q;

  // Multiplier with the implicit B[-1]=0 appended at the bottom, so triplet
  // k sits at bits [2k+2:2k] of this vector.
  logic [numbit+1:0] b_ext;
  logic [2:0]        triplet;
  logic [numbit:0]   pp_enc;
  logic              sign_enc;

  assign b_ext   = {b_q, 1'b0};
  assign triplet = b_ext[{cnt, 1'b0} +: 3];

  // M's top bit is always 0, so the left shift never loses a significant bit.
  always_comb begin
    pp_enc   = '0;
    sign_enc = 1'b0;
    case (triplet)
      3'b001, 3'b010: pp_enc = m_q;
      3'b011:         pp_enc = {m_q[numbit-1:0], 1'b0};
      3'b100: begin
        pp_enc   = ~{m_q[numbit-1:0], 1'b0};
        sign_enc = 1'b1;
      end
      3'b101, 3'b110: begin
        pp_enc   = ~m_q;
        sign_enc = 1'b1;
      end
      default: begin
        pp_enc   = '0;
        sign_enc = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      st_idle: if (in_valid)        state_nxt = st_enc;
      st_enc:  if (cnt == cnt_last) state_nxt = st_hold;
      st_hold: if (out_ready)       state_nxt = st_idle;
      default:                      state_nxt = st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= st_idle;
      cnt    <= '0;
      m_q    <= '0;
      b_q    <= '0;
      sign_q <= '0;
      for (int k = 0; k < pp_deep; k++) bank[k] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        st_idle: begin
          if (in_valid) begin
            m_q    <= {1'b0, a};
            b_q    <= {1'b0, b};
            cnt    <= '0;
            sign_q <= '0;
            for (int k = 0; k < pp_deep; k++) bank[k] <= '0;
          end
        end
        st_enc: begin
          bank[cnt]   <= pp_enc;
          sign_q[cnt] <= sign_enc;
          // Stop at the last index instead of stepping past the bank.
          if (cnt != cnt_last) cnt <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == st_idle);
  assign out_valid = (state == st_hold);
  assign busy      = (state == st_enc);

  assign pp1   = bank[0];
  assign pp2   = bank[1];
  assign pp3   = bank[2];
  assign pp4   = bank[3];
  assign pp5   = bank[4];
  assign pp6   = bank[5];
  assign signs = sign_q;

endmodule

// File: tb/tb_booth_pp_seq_enc.sv
// Testbench for booth_pp_seq_enc: directed operand pairs with hand-computed
// banks, a reset abort, backpressure and ignored-request cases, then a run
// of random pairs checked against the Booth reconstruction identity.
module tb_booth_pp_seq_enc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic        or_dir;
  logic        or_rnd;
  logic        rand_en;
  logic [11:0] pp1, pp2, pp3, pp4, pp5, pp6;
  logic [5:0]  signs;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit              exact;
    logic [5:0][11:0] pp;
    logic [5:0]      sg;
    longint          prod;
  } exp_t;

  exp_t sb[$];

  assign out_ready = rand_en ? or_rnd : or_dir;

  booth_pp_seq_enc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .pp1(pp1), .pp2(pp2), .pp3(pp3), .pp4(pp4), .pp5(pp5), .pp6(pp6),
    .signs(signs), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint inv(input logic [5:0][11:0] p, input logic [5:0] s);
    longint acc = 0;
    for (int k = 0; k < 6; k++)
      acc += (longint'(p[k]) - (s[k] ? 64'sd4096 : 64'sd0) + longint'(s[k]))
             * (64'sd1 <<< (2 * k));
    return acc;
  endfunction

  function automatic logic [5:0][11:0] cur_bank();
    return {pp6, pp5, pp4, pp3, pp2, pp1};
  endfunction

  // Monitor: pops an expectation when out_valid rises, then checks the
  // bank stays frozen for the rest of HOLD.
  initial begin
    logic             prev_ov;
    logic [5:0][11:0] held_pp;
    logic [5:0]       held_sg;
    exp_t             e;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_ov) begin
        held_pp = cur_bank();
        held_sg = signs;
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          if (e.exact) begin
            for (int k = 0; k < 6; k++)
              chk($sformatf("pp%0d", k + 1), longint'(held_pp[k]), longint'(e.pp[k]));
            chk("signs", longint'(held_sg), longint'(e.sg));
          end
          chk("invariant", inv(held_pp, held_sg), e.prod);
          chk("sign5_zero", longint'(held_sg[5]), 0);
        end
      end else if (out_valid && prev_ov) begin
        chk("hold_stable_pp", (cur_bank() == held_pp) ? 1 : 0, 1);
        chk("hold_stable_signs", longint'(signs), longint'(held_sg));
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    or_rnd = 1'b0;
    forever begin
      @(posedge clk);
      #1 or_rnd = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic push_exp(input logic [10:0] av, input logic [10:0] bv, input bit ex,
                          input logic [5:0][11:0] epp, input logic [5:0] esg);
    exp_t e;
    e.exact = ex;
    e.pp    = epp;
    e.sg    = esg;
    e.prod  = longint'(av) * longint'(bv);
    sb.push_back(e);
  endtask

  task automatic send(input logic [10:0] av, input logic [10:0] bv, input bit ex,
                      input logic [5:0][11:0] epp, input logic [5:0] esg);
    int n = 0;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
      return;
    end
    push_exp(av, bv, ex, epp, esg);
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) chk("wait_valid_timeout", 0, 1);
  endtask

  task automatic drain();
    or_dir = 1'b1;
    wait_valid();
    @(posedge clk); #1;
    or_dir = 1'b0;
  endtask

  logic [5:0][11:0] z;

  initial begin
    z        = '0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    or_dir   = 1'b0;
    rand_en  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bank_zero", (cur_bank() == z) ? 1 : 0, 1);
    chk("rst_signs", signs, 0);

    // 3*6 with backpressure: 10 cycles of HOLD with out_ready low.
    send(11'd3, 11'd6, 1'b1, {12'h0, 12'h0, 12'h0, 12'h0, 12'h006, 12'hFF9}, 6'b000001);
    chk("busy_after_accept", busy, 1);
    repeat (5) @(posedge clk);
    #0 chk("latency_not_yet_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("latency_valid_at_6", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    or_dir = 1'b1;
    @(posedge clk); #1;
    or_dir = 1'b0;
    chk("release_out_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);

    send(11'd2047, 11'd2047, 1'b1,
         {12'hFFE, 12'h0, 12'h0, 12'h0, 12'h0, 12'h800}, 6'b000001);
    drain();
    send(11'd2047, 11'd1365, 1'b1,
         {12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF}, 6'b000000);
    drain();
    send(11'd5, 11'd0, 1'b1, z, 6'b000000);
    drain();

    // Reset in the third ENC cycle of a request that must never complete.
    in_valid = 1'b1;
    a = 11'd5;
    b = 11'd2047;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_bank_zero", (cur_bank() == z) ? 1 : 0, 1);
    chk("abort_signs", signs, 0);
    send(11'd1, 11'd1, 1'b1, {12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h001}, 6'b000000);
    drain();

    // rst and in_valid together: the request is dropped.
    in_valid = 1'b1;
    rst = 1'b1;
    a = 11'd9;
    b = 11'd9;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_wins_busy", busy, 0);
    chk("rst_wins_in_ready", in_ready, 1);

    // 1*2 with a 7*7 request held up through ENC and HOLD.
    push_exp(11'd1, 11'd2, 1'b1, {12'h0, 12'h0, 12'h0, 12'h0, 12'h001, 12'hFFD}, 6'b000001);
    in_valid = 1'b1;
    a = 11'd1;
    b = 11'd2;
    @(posedge clk); #1;
    a = 11'd7;
    b = 11'd7;
    push_exp(11'd7, 11'd7, 1'b1, {12'h0, 12'h0, 12'h0, 12'h0, 12'h00E, 12'hFF8}, 6'b000001);
    wait_valid();
    repeat (3) begin
      @(posedge clk); #1;
      chk("ignored_in_ready", in_ready, 0);
    end
    or_dir = 1'b1;
    @(posedge clk); #1;
    or_dir = 1'b0;
    chk("second_waits_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("second_accepted", busy, 1);
    drain();

    // Random pairs with random out_ready duty.
    rand_en = 1'b1;
    for (int i = 0; i < 1000; i++)
      send(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)), 1'b0, z, 6'b0);
    begin
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
        @(posedge clk); #1;
        n++;
      end
      if (sb.size() != 0) chk("final_drain_timeout", sb.size(), 0);
    end
    rand_en = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
